conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/R, constraint-length-K feed-forward convolutional encoder for the transmit side of the Viterbi codec path. It accepts one information bit per valid cycle and emits R coded bits, one per generator polynomial, one clock later. The generator polynomials are run-time inputs, so one netlist serves any code of the configured K/R, e.g. the NASA K=7 (171,133) octal code. Downstream logic serialises dout[0] then dout[1] and so on; the Viterbi decoder consumes that stream.

## Interface
- K, default 7: constraint length, ≥2; shift register holds K-1 past bits.
- R, default 2: number of generator polynomials, i.e. coded bits per input bit, ≥1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- G  input  R x K (unpacked [R-1:0] of [K-1:0])  generator polynomials; G[i][K-1] taps the current input bit, G[i][0] taps the oldest bit.
- dv_in  input  1  din valid strobe.
- din  input  1  information bit.
- dv_out  output  1  dout valid, one cycle after dv_in.
- dout  output  R  coded bits; dout[i] is the bit produced by G[i].

## Operation
- State: hist[K-2:0], where hist[K-2] is the most recent previously accepted bit.
- Combinational tap vector: sr[K-1:0] = {din, hist}.
- Coded bit: dout_next[i] = XOR-reduce(sr & G[i]), for i = 0..R-1.
- On a clk edge with dv_in=1:
  - hist <= sr[K-1:1];
  - dout <= dout_next;
  - dv_out <= 1.
- On a clk edge with dv_in=0:
  - hist unchanged;
  - dout holds its last value;
  - dv_out <= 0.
- G is sampled combinationally in the same cycle as dv_in. Changing G between bits is legal and affects only later outputs.
- The encoder does not flush or insert a tail. Callers append K-1 zeros to terminate the trellis.
- The block never stalls. Every dv_in produces exactly one dv_out.

## Timing
- Reset values while rst_n=0: hist=0, dout=0, dv_out=0. Reset takes effect immediately (asynchronous); release is synchronous to clk.
- Latency is exactly one clock from dv_in/din to dv_out/dout. Throughput is one input bit per clock.
- Reset asserted mid-stream discards all history. The first bit after release is encoded against an all-zero state.
- Back-to-back dv_in gives back-to-back dv_out. Gaps in dv_in give identical gaps in dv_out.

## Configuration
- CONV_ENCODER_CLR_EN defined: adds input port clr (1 bit). When clr=1 on an edge:
  - hist <= 0, dout <= 0, dv_out <= 0;
  - clr has priority over dv_in, and a bit presented in that cycle is dropped.
- CONV_ENCODER_CLR_EN undefined: no clr port. Only rst_n clears the state.

## Structure
- Package conv_encoder_pkg:
  - default localparams CONV_K=7 and CONV_R=2;
  - typedef of the polynomial word logic[CONV_K-1:0];
  - constants for the standard polynomials: G0=7'b1111001 (171o), G1=7'b1011011 (133o).
- Sub-module conv_encoder_branch: one per polynomial, instantiated in a generate loop of R. Inputs sr and G[i]; output one parity bit.

## Test plan
- Reset: hold rst_n=0 with dv_in=1 and din toggling -> dout=00, dv_out=0. After release, the first output equals the zero-state encoding.
- Impulse response (G0=1111001, G1=1011011): din=1, then six 0s, all with dv_in=1 -> dout[0] sequence 1,1,1,1,0,0,1 and dout[1] sequence 1,0,1,1,0,1,1; afterwards 00.
- All-ones stream: twelve 1s -> after the sixth output, steady state with dout[0]=^1111001=1 and dout[1]=^1011011=1.
- dv_in gaps: pattern 1,0,1 with a two-cycle dv_in=0 gap in the middle -> the outputs equal the gap-free encoding; dv_out is low for exactly two cycles and dout holds during the gap.
- Mid-stream reset: encode 1,1,1, pulse rst_n low between edges, then encode 1 -> output 11 (the zero-state result), not the history-dependent value.
- 120-bit regression: 10 zeros, then the pattern FFF0CCAA000F3355E3ECDF8A1C1340 (MSB first), then 10 zeros -> the serialised dout[0],dout[1] stream matches a software K=7 (171,133) encoder bit-for-bit.

Source files
------------

// File: rtl/conv_encoder_pkg.sv
// conv_encoder_pkg: shared constants and types for the convolutional encoder.
// Provides the default code geometry (K=7, R=2) and the NASA (171,133) octal
// generator polynomials as ready-made constants.
// The optional synchronous clear port on the top is enabled by defining the
// macro CONV_ENCODER_CLR_EN.
package conv_encoder_pkg;

    // Default constraint length and number of generator polynomials.
    localparam int CONV_K = 7;
    localparam int CONV_R = 2;

    // One generator polynomial at the default constraint length.
    // Bit CONV_K-1 taps the current input bit, bit 0 taps the oldest bit.
    typedef logic [CONV_K-1:0] poly_t;

    // NASA K=7 code: 171 octal and 133 octal.
    localparam poly_t G0 = 7'b1111001;
    localparam poly_t G1 = 7'b1011011;

    // Parity of the taps selected by one polynomial.
    function automatic logic tap_parity(input poly_t sr, input poly_t g);
        return ^(sr & g);
    endfunction

endpackage

// File: rtl/conv_encoder_branch.sv
// conv_encoder_branch: one polynomial branch of the convolutional encoder.
// Ports: sr - tap vector {current bit, history}; g - generator polynomial;
//        p  - parity of the taps that g selects.
module conv_encoder_branch #(
    parameter int K = 7
) (
    input  logic [K-1:0] sr,
    input  logic [K-1:0] g,
    output logic         p
);

    assign p = ^(sr & g);

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/R, constraint-length-K feed-forward convolutional
// encoder. One information bit per valid cycle in, R coded bits one clock
// later out; the generator polynomials are run-time inputs.
// Ports: clk, rst_n (async, active low), G[R] polynomials, dv_in/din input
//        strobe and bit, dv_out/dout registered coded bits.
// Optional: define CONV_ENCODER_CLR_EN to add a synchronous clear input clr
//        that wipes the history and output and drops the bit in that cycle.
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int K = CONV_K,
    parameter int R = CONV_R
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef CONV_ENCODER_CLR_EN
    input  logic         clr,
`endif
    input  logic [K-1:0] G [R-1:0],
    input  logic         dv_in,
    input  logic         din,
    output logic         dv_out,
    output logic [R-1:0] dout
);

    // hist_q[K-2] is the most recently accepted bit, hist_q[0] the oldest.
    logic [K-2:0] hist_q, hist_d;
    logic [R-1:0] dout_q, dout_d;
    logic         dv_q, dv_d;

    logic [K-1:0] sr;
    logic [R-1:0] par;

    assign sr = {din, hist_q};

    for (genvar i = 0; i < R; i++) begin : g_branch
        conv_encoder_branch #(
            .K (K)
        ) u_branch (
            .sr (sr),
            .g  (G[i]),
            .p  (par[i])
        );
    end

    always_comb begin
        hist_d = hist_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (dv_in) begin
            hist_d = sr[K-1:1];
            dout_d = par;
            dv_d   = 1'b1;
        end
`ifdef CONV_ENCODER_CLR_EN
        // Clear wins over a bit presented in the same cycle.
        if (clr) begin
            hist_d = '0;
            dout_d = '0;
            dv_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    assign dv_out = dv_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: scoreboard bench for conv_encoder (K=7, R=2).
// A bit-serial software encoder predicts each output when a bit is driven.
module tb_conv_encoder;
    import conv_encoder_pkg::*;

    localparam int K = 7;
    localparam int R = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [K-1:0] g [R-1:0];
    logic         dv_in = 1'b0;
    logic         din = 1'b0;
    logic         dv_out;
    logic [R-1:0] dout;
`ifdef CONV_ENCODER_CLR_EN
    logic         clr = 1'b0;
`endif

    always #5 clk = ~clk;

    conv_encoder #(
        .K (K),
        .R (R)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef CONV_ENCODER_CLR_EN
        .clr    (clr),
`endif
        .G      (g),
        .dv_in  (dv_in),
        .din    (din),
        .dv_out (dv_out),
        .dout   (dout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [R-1:0] sb [$];
    logic [K-2:0] mh;
    logic [R-1:0] last_exp;
    logic [R-1:0] obs;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Software encoder: walk each tap bit explicitly.
    function automatic logic [R-1:0] model(input logic d);
        logic [K-1:0] s;
        logic [R-1:0] r;
        s = {d, mh};
        r = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < K; j++)
                if (g[i][j]) r[i] = r[i] ^ s[j];
        return r;
    endfunction

    task automatic model_reset();
        mh       = '0;
        last_exp = '0;
        sb.delete();
    endtask

    // Drive one cycle, then check dv_out/dout after the edge.
    task automatic step(input logic v, input logic d);
        dv_in = v;
        din   = d;
        if (v) begin
            sb.push_back(model(d));
            mh = {d, mh[K-2:1]};
        end
        @(posedge clk);
        #1;
        chk("dv_out", {31'd0, dv_out}, {31'd0, v});
        obs = dout;
        if (dv_out) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                last_exp = sb.pop_front();
                chk("dout", {30'd0, dout}, {30'd0, last_exp});
            end
        end else begin
            chk("hold", {30'd0, dout}, {30'd0, last_exp});
        end
        dv_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    logic [119:0] pat;

    initial begin
        g[0] = G0;
        g[1] = G1;
        model_reset();
        pat = 120'hFFF0CCAA000F3355E3ECDF8A1C1340;

        // Reset held with activity on the inputs.
        dv_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = i[0];
            @(posedge clk);
            #1;
            chk("rst_dout", {30'd0, dout}, 32'd0);
            chk("rst_dv", {31'd0, dv_out}, 32'd0);
        end
        dv_in = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        chk("first_zero_state", {30'd0, obs}, 32'd3);
        step(1'b0, 1'b0);

        // Impulse response against the literal polynomial bits.
        do_reset();
        for (int t = 0; t < 7; t++) begin
            step(1'b1, t == 0);
            chk("imp0", {31'd0, obs[0]}, {31'd0, G0[6-t]});
            chk("imp1", {31'd0, obs[1]}, {31'd0, G1[6-t]});
        end
        step(1'b1, 1'b0);
        chk("imp_after", {30'd0, obs}, 32'd0);

        // All-ones stream.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            step(1'b1, 1'b1);
            if (t >= 6) chk("ones_steady", {30'd0, obs}, 32'd3);
        end

        // Gaps in dv_in: dv_out low exactly two cycles, dout holds.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Mid-stream reset discards the history.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", {30'd0, dout}, 32'd0);
        chk("async_rst_dv", {31'd0, dv_out}, 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b1);
        chk("mid_rst_11", {30'd0, obs}, 32'd3);

        // Regression stream: zeros, pattern, zeros.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 120; i++) step(1'b1, pat[119-i]);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

        // Random polynomials changing between bits, random gaps.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            g[0] = 7'($urandom);
            g[1] = 7'($urandom);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom));
        end
        step(1'b0, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
